// File: rtl/btn_event_arbiter_pkg.sv
// Shared front-panel definitions: debounce default, arbiter state encoding,
// and the round-robin selection helper.
package btn_event_arbiter_pkg;

  localparam int DB_CYCLES_DEF = 2500;
  localparam int MAX_BTN       = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_t;

  // First set bit of pend searching upward from ptr, wrapping at n channels.
  function automatic logic [2:0] rr_pick(input logic [MAX_BTN-1:0] pend,
                                         input logic [2:0] ptr,
                                         input int n);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_BTN; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !found && pend[idx]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/btn_event_arbiter_qualify.sv
// Single-channel debounce: counts consecutive high samples and emits one
// press strobe per continuous high period of at least DB_CYCLES cycles.
module btn_qualify #(
  parameter int DB_CYCLES = 2500,
  parameter int CNT_W     = 12
) (
  input  logic clk,
  input  logic nrst,
  input  logic btn_raw,
  output logic press
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!nrst || !btn_raw) begin
      cnt <= '0;
    end else if (cnt != CNT_W'(DB_CYCLES)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Saturation at DB_CYCLES keeps a held button from re-firing.
  assign press = btn_raw && (cnt == CNT_W'(DB_CYCLES - 1));

endmodule

// File: rtl/btn_event_arbiter.sv
// Front-panel controller: debounced presses become pending events, offered
// round-robin on a single valid/ready port.
module btn_event_arbiter
  import btn_event_arbiter_pkg::*;
#(
  parameter int N_BTN     = 4,
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = 12,
  parameter int ID_W      = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  input  logic             evt_ready,
  output logic [N_BTN-1:0] pending,
  output logic             overrun
);

  // Handshake: an event transfers on a cycle where evt_valid and evt_ready
  // are both high; once raised, evt_valid and evt_id hold until that transfer.

  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] clr;
  logic [N_BTN-1:0] drop;
  logic [ID_W-1:0]  ptr;
  arb_state_t       state;

  for (genvar g = 0; g < N_BTN; g++) begin : g_qual
    btn_qualify #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W)
    ) u_qual (
      .clk    (clk),
      .nrst   (nrst),
      .btn_raw(btn_raw[g]),
      .press  (press[g])
    );
  end

  always_comb begin
    clr = '0;
    if (state == ST_OFFER && evt_ready) clr[evt_id] = 1'b1;
    // A press on the channel being accepted this cycle re-arms it cleanly.
    drop = press & pending & ~clr;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | press;
      overrun <= |drop;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= ST_IDLE;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      ptr       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|pending) begin
            evt_id    <= ID_W'(rr_pick(MAX_BTN'(pending), 3'(ptr), N_BTN));
            evt_valid <= 1'b1;
            state     <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (evt_ready) begin
            ptr       <= (evt_id == ID_W'(N_BTN - 1)) ? '0 : evt_id + 1'b1;
            evt_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          evt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Bench for btn_event_arbiter with N_BTN=4, DB_CYCLES=4: directed scenarios
// and random traffic checked against a cycle-level behavioural model.
module tb_btn_event_arbiter;

  localparam int N   = 4;
  localparam int DB  = 4;
  localparam int IDW = 2;
  localparam int OW  = 1 + IDW + N + 1;

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic [N-1:0]   btn_raw = '0;
  logic           evt_ready = 1'b0;
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic [N-1:0]   pending;
  logic           overrun;

  int checks = 0;
  int errors = 0;

  int           m_run[N] = '{default: 0};
  logic [N-1:0] m_pend = '0;
  logic         m_valid = 1'b0;
  int           m_id = 0;
  int           m_ptr = 0;
  logic         m_ovr = 1'b0;

  logic [IDW-1:0] acc_q[$];
  logic [IDW-1:0] exp_q[$];

  btn_event_arbiter #(
    .N_BTN    (N),
    .DB_CYCLES(DB),
    .CNT_W    (12),
    .ID_W     (IDW)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .btn_raw  (btn_raw),
    .evt_valid(evt_valid),
    .evt_id   (evt_id),
    .evt_ready(evt_ready),
    .pending  (pending),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] dut_obs();
    return {evt_valid, evt_id, pending, overrun};
  endfunction

  function automatic logic [OW-1:0] mdl_obs();
    return {m_valid, IDW'(m_id), m_pend, m_ovr};
  endfunction

  // Behavioural model: a press is the DB-th consecutive high sample; events are
  // offered from the registered pending set, round-robin from after the last grant.
  task automatic model_edge();
    logic [N-1:0] press;
    logic [N-1:0] old_pend;
    logic         acc;
    int           pick;
    int           idx;
    if (!nrst) begin
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_pend = '0; m_valid = 1'b0; m_id = 0; m_ptr = 0; m_ovr = 1'b0;
    end else begin
      old_pend = m_pend;
      acc      = m_valid && evt_ready;
      m_ovr    = 1'b0;
      for (int i = 0; i < N; i++) press[i] = btn_raw[i] && (m_run[i] + 1 == DB);
      for (int i = 0; i < N; i++) begin
        if (press[i]) begin
          if (old_pend[i] && !(acc && m_id == i)) m_ovr = 1'b1;
          m_pend[i] = 1'b1;
        end else if (acc && m_id == i) begin
          m_pend[i] = 1'b0;
        end
      end
      if (m_valid) begin
        if (evt_ready) begin
          m_valid = 1'b0;
          m_ptr   = (m_id + 1) % N;
        end
      end else begin
        pick = -1;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (pick < 0 && old_pend[idx]) pick = idx;
        end
        if (pick >= 0) begin
          m_valid = 1'b1;
          m_id    = pick;
        end
      end
      for (int i = 0; i < N; i++)
        m_run[i] = btn_raw[i] ? ((m_run[i] < 1000) ? m_run[i] + 1 : 1000) : 0;
    end
  endtask

  task automatic step();
    if (nrst && evt_valid && evt_ready) acc_q.push_back(evt_id);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quick_reset();
    nrst = 1'b0; btn_raw = '0; evt_ready = 1'b0;
    step();
    nrst = 1'b1;
    acc_q.delete();
  endtask

  task automatic test_reset();
    nrst = 1'b0; btn_raw = '1; evt_ready = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if (dut_obs() !== '0) begin
        errors++; $display("FAIL reset_outputs got=%h exp=0", dut_obs());
      end
    end
    nrst = 1'b1; btn_raw = '0; evt_ready = 1'b0;
    step();
  endtask

  task automatic test_bounce();
    logic [6:0] pat;
    pat = 7'b0110111;
    for (int c = 0; c < 11; c++) begin
      btn_raw = '0;
      btn_raw[1] = (c < 7) ? pat[c] : 1'b0;
      step();
      checks++;
      if (dut_obs() !== mdl_obs()) begin
        errors++; $display("FAIL bounce_model c=%0d got=%h exp=%h", c, dut_obs(), mdl_obs());
      end
      checks++;
      if (evt_valid !== 1'b0 || pending !== '0) begin
        errors++; $display("FAIL bounce_quiet c=%0d got valid=%b pend=%b exp 0/0", c, evt_valid, pending);
      end
    end
  endtask

  task automatic test_single_press();
    int nvalid;
    quick_reset();
    btn_raw = 4'b0100; evt_ready = 1'b1; nvalid = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (evt_valid === 1'b1) nvalid++;
      checks++;
      if (dut_obs() !== mdl_obs()) begin
        errors++; $display("FAIL single_model c=%0d got=%h exp=%h", c, dut_obs(), mdl_obs());
      end
      if (c == 4) begin
        checks++;
        if (pending !== 4'b0100) begin
          errors++; $display("FAIL single_pend_t4 got=%b exp=0100", pending);
        end
      end
      if (c == 5) begin
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
          errors++; $display("FAIL single_offer_t5 got v=%b id=%0d exp v=1 id=2", evt_valid, evt_id);
        end
      end
    end
    btn_raw = '0;
    step();
    checks++;
    if (nvalid != 1 || acc_q.size() != 1 || acc_q[0] !== 2'd2) begin
      errors++; $display("FAIL single_count got valid_cycles=%0d accepted=%0d exp 1/1", nvalid, acc_q.size());
    end
  endtask

  task automatic test_round_robin();
    logic exp_v;
    quick_reset();
    btn_raw = '1; evt_ready = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      exp_v = (c == 5 || c == 7 || c == 9 || c == 11);
      checks++;
      if (dut_obs() !== mdl_obs() || evt_valid !== exp_v) begin
        errors++; $display("FAIL rr_cycle c=%0d got=%h exp=%h valid_exp=%b", c, dut_obs(), mdl_obs(), exp_v);
      end
    end
    btn_raw = '0;
    step();
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    checks++;
    if (acc_q != exp_q || pending !== '0) begin
      errors++; $display("FAIL rr_order got=%p pend=%b exp=%p pend=0", acc_q, pending, exp_q);
    end
  endtask

  task automatic test_backpressure();
    int n;
    quick_reset();
    btn_raw = 4'b0010;
    repeat (4) step();
    btn_raw = '0;
    n = 0;
    while (!evt_valid && n < 20) begin step(); n++; end
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
      errors++; $display("FAIL bp_first_offer got v=%b id=%0d exp v=1 id=1", evt_valid, evt_id);
    end
    btn_raw = 4'b1000;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) btn_raw = '0;
      step();
      checks++;
      if (dut_obs() !== mdl_obs() || evt_valid !== 1'b1 || evt_id !== 2'd1) begin
        errors++; $display("FAIL bp_hold c=%0d got=%h exp=%h id_exp=1", c, dut_obs(), mdl_obs());
      end
    end
    evt_ready = 1'b1;
    repeat (6) step();
    exp_q = '{2'd1, 2'd3};
    checks++;
    if (acc_q != exp_q) begin
      errors++; $display("FAIL bp_order got=%p exp=%p", acc_q, exp_q);
    end
  endtask

  task automatic test_overrun();
    int ovr;
    int n;
    logic [4:0] seq;
    quick_reset();
    ovr = 0;
    seq = 5'b11110;
    for (int c = 0; c < 12; c++) begin
      btn_raw = (c < 9 && c != 4) ? 4'b0001 : 4'b0000;
      step();
      if (overrun === 1'b1) ovr++;
      checks++;
      if (dut_obs() !== mdl_obs()) begin
        errors++; $display("FAIL ovr_model c=%0d got=%h exp=%h", c, dut_obs(), mdl_obs());
      end
    end
    evt_ready = 1'b1;
    repeat (4) step();
    evt_ready = 1'b0;
    exp_q = '{2'd0};
    checks++;
    if (ovr != 1 || acc_q != exp_q) begin
      errors++; $display("FAIL ovr_drop got pulses=%0d acc=%p exp pulses=1 acc=%p", ovr, acc_q, exp_q);
    end
    acc_q.delete(); ovr = 0;
    btn_raw = 4'b0001;
    repeat (4) step();
    btn_raw = '0;
    n = 0;
    while (!evt_valid && n < 20) begin step(); n++; end
    btn_raw = 4'b0001;
    for (int c = 0; c < 9; c++) begin
      evt_ready = seq[(c < 5) ? c : 4];
      evt_ready = (c >= 3);
      if (c == 4) btn_raw = '0;
      step();
      if (overrun === 1'b1) ovr++;
      checks++;
      if (dut_obs() !== mdl_obs()) begin
        errors++; $display("FAIL ovr_accept_model c=%0d got=%h exp=%h", c, dut_obs(), mdl_obs());
      end
    end
    exp_q = '{2'd0, 2'd0};
    checks++;
    if (ovr != 0 || acc_q != exp_q) begin
      errors++; $display("FAIL ovr_on_accept got pulses=%0d acc=%p exp pulses=0 acc=%p", ovr, acc_q, exp_q);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_reset_mid_offer();
    int n;
    quick_reset();
    btn_raw = 4'b0100;
    n = 0;
    while (!evt_valid && n < 20) begin step(); n++; end
    nrst = 1'b0;
    step();
    checks++;
    if (dut_obs() !== '0) begin
      errors++; $display("FAIL midoffer_reset got=%h exp=0", dut_obs());
    end
    nrst = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      checks++;
      if (pending[2] !== (c >= 4) || dut_obs() !== mdl_obs()) begin
        errors++; $display("FAIL midoffer_requal c=%0d got=%h exp=%h", c, dut_obs(), mdl_obs());
      end
    end
    btn_raw = '0; evt_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_random();
    quick_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) btn_raw[i] = ~btn_raw[i];
      evt_ready = ($urandom_range(0, 3) != 0);
      nrst = ($urandom_range(0, 499) != 0);
      step();
      checks++;
      if (dut_obs() !== mdl_obs()) begin
        errors++; $display("FAIL random_model c=%0d got=%h exp=%h", c, dut_obs(), mdl_obs());
      end
    end
    nrst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_single_press();
    test_round_robin();
    test_backpressure();
    test_overrun();
    test_reset_mid_offer();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
